systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencer for the 4x4 output-stationary systolic multiply array. It latches two 4x4 operand matrices on a start request, clears the array accumulators, and drives the west and north edges with the diagonally skewed operand streams. It waits for the wavefront to drain, then pulses `done`. It sits between the operand source (host/register file) and the array's `inp_west*` / `inp_north*` edge ports.

## Interface
- `DW`, default 8: operand element width; array edge lanes are `DW` bits.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a multiply; sampled only in IDLE or DONE.
- `a_mat`  in  16*DW  matrix A; A[i][k] at bits [(4i+k)*DW +: DW].
- `b_mat`  in  16*DW  matrix B; B[k][j] at bits [(4k+j)*DW +: DW].
- `west0..west3`  out  DW each  row-i west edge operand, registered.
- `north0..north3`  out  DW each  column-j north edge operand, registered.
- `pe_clr`  out  1  accumulator clear to all PEs, registered.
- `pe_en`  out  1  PE advance enable, registered.
- `busy`  out  1  high in CLEAR, FEED and DRAIN.
- `done`  out  1  one-cycle completion pulse; results are valid on the array outputs.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE. Step counter `t` is 4 bits.
- IDLE:
  - All outputs are 0.
  - `start`=1 latches `a_mat`/`b_mat` into internal registers and moves to CLEAR.
- CLEAR, one cycle:
  - `pe_clr`=1, `pe_en`=0, edges 0, `t` set to 0.
  - Then go to FEED.
- FEED, `t`=0..6:
  - `pe_en`=1.
  - `west_i` = A[i][t-i] when 0 ≤ t-i ≤ 3, else 0.
  - `north_j` = B[t-j][j] when 0 ≤ t-j ≤ 3, else 0.
  - `t` increments each cycle. After `t`=6, go to DRAIN.
- DRAIN, `t`=7..9:
  - `pe_en`=1, all edges 0.
  - After `t`=9, go to DONE.
- DONE, one cycle:
  - `done`=1, `pe_en`=0, edges 0.
  - `start`=1 here re-latches operands and goes directly to CLEAR (back-to-back operation). Otherwise go to IDLE.
- `start` in CLEAR, FEED or DRAIN is ignored. It is not queued.
- Latched operands are used for the whole job. Changes on `a_mat`/`b_mat` after acceptance have no effect.
- No arithmetic in this block; accumulation width and overflow belong to the PEs.

## Timing
- Reset (async, `rst`=0): state IDLE, `t`=0, operand registers 0, and every output 0 (`west*`, `north*`, `pe_clr`, `pe_en`, `busy`, `done`).
- Reset deassertion takes effect at the next rising edge.
- Reset mid-job aborts immediately. Outputs go to 0 asynchronously and no `done` is produced.
- Let edge E0 be the edge that samples `start`=1. Then:
  - Cycle after E0: CLEAR, with `pe_clr`=1 and `busy`=1.
  - Cycles 2..8: FEED with `t`=0..6.
  - Cycles 9..11: DRAIN.
  - Cycle 12: `done`=1 and `busy`=0.
- Start-to-done latency is 12 cycles. Back-to-back period is 12 cycles.
- Element A[i][k] and B[k][j] meet in PE(i,j) at step t = i+j+k. The last product (i=j=k=3) occurs at `t`=9, the final DRAIN cycle.

## Test plan
- Skew check:
  - Stimulus: A[i][k]=16i+k, B[k][j]=16k+j+128, then `start`.
  - At `t`=3: `west0..3` = 0x03,0x12,0x21,0x30 and `north0..3` = 0xB0,0xA1,0x92,0x83.
  - At `t`=0: only `west0`=0x00 and `north0`=0x80 carry data; all other lanes are 0.
- Full job with array attached:
  - Stimulus: A = identity, B[k][j]=4k+j+1.
  - `done` occurs exactly 12 cycles after start; `out00..out15` = 1..16.
- Busy ignore:
  - Stimulus: pulse `start` again at cycle 5 with different operands.
  - Edge values are unchanged, a single `done` at cycle 12, and no second job.
- Back-to-back:
  - Stimulus: hold `start`=1 continuously.
  - `done` at cycles 12, 24, 36; `pe_clr` at cycles 1, 13, 25.
- Reset mid-FEED:
  - Stimulus: assert `rst`=0 at `t`=4.
  - All outputs 0 immediately and state IDLE. After release, a new `start` yields a correct result with no `done` from the aborted job.
- Operand stability:
  - Stimulus: change `a_mat`/`b_mat` every cycle after acceptance.
  - Edge streams match the values captured at E0.

Source files
------------

// File: rtl/systolic_seq_ctrl_if.sv
// Operand/edge bundle between the host, the sequencer and the 4x4 systolic array.
// Master = operand source, slave = sequencer.
interface systolic_seq_ctrl_if #(
  parameter int DW = 8
) ();
  logic             start;
  logic [16*DW-1:0] a_mat;
  logic [16*DW-1:0] b_mat;
  logic [DW-1:0]    west0, west1, west2, west3;
  logic [DW-1:0]    north0, north1, north2, north3;
  logic             pe_clr;
  logic             pe_en;
  logic             busy;
  logic             done;

  modport master (
    output start, a_mat, b_mat,
    input  west0, west1, west2, west3,
    input  north0, north1, north2, north3,
    input  pe_clr, pe_en, busy, done
  );

  modport slave (
    input  start, a_mat, b_mat,
    output west0, west1, west2, west3,
    output north0, north1, north2, north3,
    output pe_clr, pe_en, busy, done
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 4x4 output-stationary systolic array: latches A/B, clears the PEs,
// feeds diagonally skewed edge streams, drains the wavefront and pulses done.
module systolic_seq_ctrl #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  systolic_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             t_reg, t_next;
  logic [16*DW-1:0]       a_reg, a_next, b_reg, b_next;
  logic [3:0][DW-1:0]     west_reg, west_next, north_reg, north_next;
  logic                   clr_reg, clr_next, en_reg, en_next;
  logic                   busy_reg, busy_next, done_reg, done_next;

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        t_next     = 4'd0;
        if (bus.start) begin
          state_next = CLEAR;
          a_next     = bus.a_mat;
          b_next     = bus.b_mat;
        end
      end
      CLEAR: begin
        state_next = FEED;
        t_next     = 4'd0;
      end
      FEED: begin
        t_next = t_reg + 4'd1;
        if (t_reg == 4'd6) state_next = DRAIN;
      end
      DRAIN: begin
        t_next = t_reg + 4'd1;
        if (t_reg == 4'd9) state_next = DONE;
      end
      default: begin
        state_next = IDLE;
        t_next     = 4'd0;
      end
    endcase
    // Outputs are decoded from the next state so they register alongside it.
    clr_next  = (state_next == CLEAR);
    en_next   = (state_next == FEED) || (state_next == DRAIN);
    busy_next = (state_next == CLEAR) || (state_next == FEED) || (state_next == DRAIN);
    done_next = (state_next == DONE);
  end

  // Lane gi carries element k = t - gi; negative k wraps high in 5 bits and is rejected.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [4:0] d_w;
    logic       live_w;
    assign d_w    = {1'b0, t_next} - 5'(gi);
    assign live_w = (state_next == FEED) && (d_w < 5'd4);
    assign west_next[gi]  = live_w ? a_reg[(4*gi + int'(d_w[1:0]))*DW +: DW] : '0;
    assign north_next[gi] = live_w ? b_reg[(4*int'(d_w[1:0]) + gi)*DW +: DW] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      t_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      west_reg  <= '0;
      north_reg <= '0;
      clr_reg   <= 1'b0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      west_reg  <= west_next;
      north_reg <= north_next;
      clr_reg   <= clr_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.west0  = west_reg[0];
  assign bus.west1  = west_reg[1];
  assign bus.west2  = west_reg[2];
  assign bus.west3  = west_reg[3];
  assign bus.north0 = north_reg[0];
  assign bus.north1 = north_reg[1];
  assign bus.north2 = north_reg[2];
  assign bus.north3 = north_reg[3];
  assign bus.pe_clr = clr_reg;
  assign bus.pe_en  = en_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl with a behavioural 4x4 array on the edges.
module tb_systolic_seq_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.DW(DW)) bus ();
  systolic_seq_ctrl #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0]       cyc;
    logic              clr, en, busy, done;
    logic [3:0][7:0]   w;
    logic [3:0][7:0]   n;
  } rec_t;

  rec_t              exp_q[$];
  logic [15:0][19:0] res_q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Behavioural output-stationary array driven by the sequencer edges.
  logic [3:0][7:0]       west_v, north_v;
  logic [3:0][3:0][7:0]  a_in, b_in, a_pipe, b_pipe;
  logic [15:0][19:0]     acc;
  assign west_v  = {bus.west3, bus.west2, bus.west1, bus.west0};
  assign north_v = {bus.north3, bus.north2, bus.north1, bus.north0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_in[i][0] = west_v[i];
      b_in[0][i] = north_v[i];
      for (int j = 1; j < 4; j++) begin
        a_in[i][j] = a_pipe[i][j-1];
        b_in[j][i] = b_pipe[j-1][i];
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst || bus.pe_clr) begin
      a_pipe <= '0;
      b_pipe <= '0;
      acc    <= '0;
    end else if (bus.pe_en) begin
      a_pipe <= a_in;
      b_pipe <= b_in;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc[4*i+j] <= acc[4*i+j] + 20'(a_in[i][j]) * 20'(b_in[i][j]);
    end
  end

  // Expected per-cycle edge records and final product for a job whose E0 follows cycle c0.
  function automatic void push_job(input logic [127:0] a, input logic [127:0] b, input int c0);
    logic [15:0][19:0] c;
    for (int s = 1; s <= 12; s++) begin
      rec_t r;
      r     = '0;
      r.cyc = 32'(c0 + s);
      if (s == 1) begin
        r.clr = 1'b1; r.busy = 1'b1;
      end else if (s <= 8) begin
        r.en = 1'b1; r.busy = 1'b1;
        for (int l = 0; l < 4; l++) begin
          if ((s - 2 - l) >= 0 && (s - 2 - l) <= 3) begin
            r.w[l] = a[(4*l + (s-2-l))*8 +: 8];
            r.n[l] = b[(4*(s-2-l) + l)*8 +: 8];
          end
        end
      end else if (s <= 11) begin
        r.en = 1'b1; r.busy = 1'b1;
      end else begin
        r.done = 1'b1;
      end
      exp_q.push_back(r);
    end
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 4; k++)
          c[4*i+j] = c[4*i+j] + 20'(a[(4*i+k)*8 +: 8]) * 20'(b[(4*k+j)*8 +: 8]);
    res_q.push_back(c);
  endfunction

  always @(negedge clk) begin
    rec_t              act, e;
    logic [15:0][19:0] er;
    act = {32'(cyc), bus.pe_clr, bus.pe_en, bus.busy, bus.done, west_v, north_v};
    if (act.busy || act.done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got %h required no activity", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL edge_record: got %h required %h", act, e);
        end
      end
      if (act.done) begin
        tests++;
        if (res_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          er = res_q.pop_front();
          if (acc !== er) begin
            fails++;
            $display("FAIL array_result: got %h required %h", acc, er);
          end
        end
      end
    end else begin
      tests++;
      if ({act.clr, act.en, act.w, act.n} !== '0) begin
        fails++;
        $display("FAIL idle_outputs: got %h required 0", act);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  function automatic logic [63:0] lanes();
    return {west_v, north_v};
  endfunction

  function automatic logic [63:0] ctrl();
    return 64'({bus.pe_clr, bus.pe_en, bus.busy, bus.done});
  endfunction

  task automatic issue(input logic [127:0] a, input logic [127:0] b);
    bus.a_mat = a;
    bus.b_mat = b;
    bus.start = 1'b1;
    push_job(a, b, cyc);
    tick();
    bus.start = 1'b0;
  endtask

  logic [127:0] a_skew, b_skew, a_id, b_id, a_x, b_x;

  initial begin
    bus.start = 1'b0;
    bus.a_mat = '0;
    bus.b_mat = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a_skew[(4*i+k)*8 +: 8] = 8'(16*i + k);
        b_skew[(4*i+k)*8 +: 8] = 8'(16*i + k + 128);
        a_id[(4*i+k)*8 +: 8]   = (i == k) ? 8'd1 : 8'd0;
        b_id[(4*i+k)*8 +: 8]   = 8'(4*i + k + 1);
        a_x[(4*i+k)*8 +: 8]    = 8'(3*i + 5*k + 7);
        b_x[(4*i+k)*8 +: 8]    = 8'(11*i + k + 2);
      end
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("reset_lanes", lanes(), 64'h0);
    chk("reset_ctrl", ctrl(), 64'h0);
    rst = 1'b1;
    repeat (2) tick();

    // Skew: hand-computed lanes at t=0 and t=3.
    issue(a_skew, b_skew);
    chk("clear_ctrl", ctrl(), 64'h0000_0000_0000_000A);
    tick();
    chk("t0_lanes", lanes(), 64'h0000_0000_0000_0080);
    chk("t0_ctrl", ctrl(), 64'h0000_0000_0000_0006);
    repeat (3) tick();
    chk("t3_lanes", lanes(), 64'h3021_1203_8392_A1B0);
    repeat (10) tick();

    // Identity A with array attached: results 1..16.
    issue(a_id, b_id);
    repeat (14) tick();

    // Start while busy is ignored.
    issue(a_skew, b_skew);
    repeat (4) tick();
    bus.a_mat = a_x;
    bus.b_mat = b_x;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();

    // Back-to-back with start held: done at 12, 24, 36.
    bus.a_mat = a_x;
    bus.b_mat = b_x;
    bus.start = 1'b1;
    push_job(a_x, b_x, cyc);
    push_job(a_x, b_x, cyc + 12);
    push_job(a_x, b_x, cyc + 24);
    repeat (26) tick();
    bus.start = 1'b0;
    repeat (14) tick();

    // Reset at t=4 aborts the job asynchronously.
    issue(a_x, b_x);
    repeat (5) tick();
    rst = 1'b0;
    exp_q.delete();
    res_q.delete();
    #1;
    chk("abort_lanes", lanes(), 64'h0);
    chk("abort_ctrl", ctrl(), 64'h0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    issue(a_skew, b_skew);
    repeat (14) tick();

    // Operand inputs churn after acceptance.
    issue(a_x, b_id);
    for (int c = 0; c < 14; c++) begin
      bus.a_mat = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.b_mat = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    repeat (4) tick();

    chk("leftover_records", 64'(exp_q.size()), 64'h0);
    chk("leftover_results", 64'(res_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
